// File: rtl/dict_match_scheduler_pkg.sv
// Shared types and constants for the dictionary-match scheduler.
// Holds the FSM state type, the best-match record and the full-match count.
package dict_match_scheduler_pkg;

    localparam int         MAX_IDX_W      = 16;
    localparam logic [1:0] FULL_MATCH_CNT = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        RESULT,
        UPDATE
    } state_e;

    typedef struct packed {
        logic                 hit;
        logic [MAX_IDX_W-1:0] idx;
        logic [1:0]           count;
    } match_res_t;

endpackage

// File: rtl/dict_match_scheduler_if.sv
// Word-input and result handshake bundle of the dictionary-match scheduler.
// The slave modport is the scheduler side; the master modport is its environment.
interface dict_match_scheduler_if #(
    parameter int DICT_DEPTH = 16
);
    localparam int IDX_W = $clog2(DICT_DEPTH);

    logic             i_word_valid;
    logic             o_word_ready;
    logic [31:0]      i_word;
    logic             i_flush;
    logic             o_res_valid;
    logic             i_res_ready;
    logic             o_res_hit;
    logic [IDX_W-1:0] o_res_idx;
    logic [1:0]       o_res_count;
    logic [31:0]      o_res_word;

    modport slave (
        input  i_word_valid, i_word, i_flush, i_res_ready,
        output o_word_ready, o_res_valid, o_res_hit, o_res_idx, o_res_count, o_res_word
    );

    modport master (
        output i_word_valid, i_word, i_flush, i_res_ready,
        input  o_word_ready, o_res_valid, o_res_hit, o_res_idx, o_res_count, o_res_word
    );

endinterface

// File: rtl/dict_match_scheduler_word_decoder.sv
// Turns a 4-bit byte-equality vector into a match count and a contiguity flag.
// count: 4 equal bytes -> 3, 3 -> 2, 2 -> 1, fewer -> 0; align: set bits contiguous and non-empty.
module word_decoder (
    input  logic [3:0] cmp,
    output logic [1:0] count,
    output logic       align
);

    always_comb begin
        count = 2'd0;
        align = 1'b0;
        case (cmp)
            4'b1111:                                     count = 2'd3;
            4'b0111, 4'b1011, 4'b1101, 4'b1110:          count = 2'd2;
            4'b0011, 4'b0101, 4'b0110, 4'b1001,
            4'b1010, 4'b1100:                            count = 2'd1;
            default:                                     count = 2'd0;
        endcase
        case (cmp)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b0110, 4'b1100,
            4'b0111, 4'b1110, 4'b1111:                   align = 1'b1;
            default:                                     align = 1'b0;
        endcase
    end

endmodule

// File: rtl/dict_match_scheduler.sv
// FIFO-replacement dictionary search: one entry compared per cycle, best match reported.
// Optional DICT_EARLY_EXIT_EN ends the scan on the first full match.
module dict_match_scheduler
    import dict_match_scheduler_pkg::*;
#(
    parameter int DICT_DEPTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    dict_match_scheduler_if.slave  bus
);

    localparam int IDX_W = $clog2(DICT_DEPTH);

    state_e           state;
    logic [31:0]      dict_mem [DICT_DEPTH];
    logic [DICT_DEPTH-1:0] dict_vld;
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W-1:0] scan_idx;
    logic             flush_pend;
    logic [31:0]      word_q;
    match_res_t       best;
    match_res_t       best_nxt;
    logic             word_ready_q;
    logic             res_valid_q;
    match_res_t       res_q;
    logic [31:0]      res_word_q;
    logic [3:0]       cmp_vec;
    logic [1:0]       dec_count;
    logic             dec_align;
    logic             qualify;
    logic             scan_last;
    logic             scan_done;
    logic             word_acc;
    logic             unused_idx_hi;

    function automatic logic [3:0] byte_cmp(input logic [31:0] a, input logic [31:0] b);
        logic [3:0] eq;
        for (int k = 0; k < 4; k++) begin
            eq[k] = (a[8*k +: 8] == b[8*k +: 8]);
        end
        return eq;
    endfunction

    assign cmp_vec = byte_cmp(word_q, dict_mem[scan_idx]);

    word_decoder u_word_decoder (
        .cmp   (cmp_vec),
        .count (dec_count),
        .align (dec_align)
    );

    assign qualify   = dec_align && (dec_count != 2'd0);
    // Entries fill from index 0, so the first invalid slot marks the end of the scan.
    assign scan_last = (scan_idx == IDX_W'(DICT_DEPTH - 1)) || !dict_vld[scan_idx + IDX_W'(1)];
    assign word_acc  = bus.i_word_valid && word_ready_q;

`ifdef DICT_EARLY_EXIT_EN
    assign scan_done = scan_last || (qualify && (dec_count == FULL_MATCH_CNT));
`else
    assign scan_done = scan_last;
`endif

    // Strictly greater count wins, so ties keep the lower index.
    always_comb begin
        best_nxt = best;
        if (qualify && (!best.hit || (dec_count > best.count))) begin
            best_nxt.hit   = 1'b1;
            best_nxt.idx   = MAX_IDX_W'(scan_idx);
            best_nxt.count = dec_count;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= IDLE;
            dict_vld     <= '0;
            wr_ptr       <= '0;
            flush_pend   <= 1'b0;
            word_ready_q <= 1'b0;
            res_valid_q  <= 1'b0;
            res_q        <= '0;
            res_word_q   <= '0;
        end else begin
            if (bus.i_flush) flush_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (flush_pend) begin
                        dict_vld     <= '0;
                        flush_pend   <= bus.i_flush;
                        word_ready_q <= !bus.i_flush;
                    end else if (word_acc) begin
                        word_ready_q <= 1'b0;
                        if (|dict_vld) begin
                            state <= SCAN;
                        end else begin
                            state       <= RESULT;
                            res_valid_q <= 1'b1;
                            res_q       <= '0;
                            res_word_q  <= bus.i_word;
                        end
                    end else begin
                        word_ready_q <= !bus.i_flush;
                    end
                end
                SCAN: begin
                    if (scan_done) begin
                        state       <= RESULT;
                        res_valid_q <= 1'b1;
                        res_q       <= best_nxt;
                        res_word_q  <= word_q;
                    end
                end
                RESULT: begin
                    if (bus.i_res_ready) begin
                        state       <= UPDATE;
                        res_valid_q <= 1'b0;
                    end
                end
                UPDATE: begin
                    // A full match already lives in the dictionary; anything else is inserted.
                    if (res_q.count != FULL_MATCH_CNT) begin
                        dict_vld[wr_ptr] <= 1'b1;
                        wr_ptr           <= wr_ptr + IDX_W'(1);
                    end
                    state        <= IDLE;
                    word_ready_q <= !(flush_pend || bus.i_flush);
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (word_acc) begin
            word_q   <= bus.i_word;
            scan_idx <= '0;
            best     <= '0;
        end else if (state == SCAN) begin
            scan_idx <= scan_idx + IDX_W'(1);
            best     <= best_nxt;
        end
        if ((state == UPDATE) && (res_q.count != FULL_MATCH_CNT)) begin
            dict_mem[wr_ptr] <= word_q;
        end
    end

    assign bus.o_word_ready = word_ready_q;
    assign bus.o_res_valid  = res_valid_q;
    assign bus.o_res_hit    = res_q.hit;
    assign bus.o_res_idx    = res_q.idx[IDX_W-1:0];
    assign bus.o_res_count  = res_q.count;
    assign bus.o_res_word   = res_word_q;
    assign unused_idx_hi    = ^res_q.idx[MAX_IDX_W-1:IDX_W];

endmodule

// File: tb/tb_dict_match_scheduler.sv
// Directed self-checking bench for dict_match_scheduler (DICT_DEPTH = 16).
// Latency expectations follow DICT_EARLY_EXIT_EN when it is defined.
module tb_dict_match_scheduler;

    localparam int DICT_DEPTH = 16;
    localparam int IDX_W      = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic             r_hit;
    logic [IDX_W-1:0] r_idx;
    logic [1:0]       r_cnt;
    logic [31:0]      r_word;
    int               r_lat;

    dict_match_scheduler_if #(.DICT_DEPTH(DICT_DEPTH)) bus ();

    dict_match_scheduler #(.DICT_DEPTH(DICT_DEPTH)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!bus.o_word_ready && guard < 50) begin
            step();
            guard++;
        end
        if (!bus.o_word_ready) begin
            errors++;
            $display("FAIL word_ready_timeout: o_word_ready=%0b after %0d cycles, expected 1", bus.o_word_ready, guard);
        end
        checks++;
    endtask

    task automatic wait_res_valid(output int lat);
        lat = 1;
        while (!bus.o_res_valid && lat < 40) begin
            step();
            lat++;
        end
        if (!bus.o_res_valid) begin
            errors++;
            $display("FAIL res_valid_timeout: o_res_valid=%0b after %0d cycles, expected 1", bus.o_res_valid, lat);
        end
        checks++;
    endtask

    // One full transaction: offer the word, capture the result and its latency, accept it.
    task automatic do_word(input logic [31:0] w);
        wait_ready();
        bus.i_word_valid = 1'b1;
        bus.i_word       = w;
        step();
        bus.i_word_valid = 1'b0;
        wait_res_valid(r_lat);
        r_hit  = bus.o_res_hit;
        r_idx  = bus.o_res_idx;
        r_cnt  = bus.o_res_count;
        r_word = bus.o_res_word;
        bus.i_res_ready = 1'b1;
        step();
        bus.i_res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        if ({bus.o_word_ready, bus.o_res_valid, bus.o_res_hit, bus.o_res_idx, bus.o_res_count, bus.o_res_word} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%0b valid=%0b hit=%0b idx=%0d cnt=%0d word=%h, expected all 0",
                     bus.o_word_ready, bus.o_res_valid, bus.o_res_hit, bus.o_res_idx, bus.o_res_count, bus.o_res_word);
        end
        checks++;
        rst = 1'b0;
        step();
        if (bus.o_word_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_rise: o_word_ready=%0b, expected 1", bus.o_word_ready);
        end
        checks++;
    endtask

    task automatic test_empty_dict();
        do_word(32'h11223344);
        if ({r_hit, r_idx, r_cnt, r_word} !== {1'b0, 4'd0, 2'd0, 32'h11223344} || r_lat != 1) begin
            errors++;
            $display("FAIL empty_first: hit=%0b idx=%0d cnt=%0d word=%h lat=%0d, expected 0/0/0/11223344 lat 1", r_hit, r_idx, r_cnt, r_word, r_lat);
        end
        checks++;
        do_word(32'h11223344);
        if ({r_hit, r_idx, r_cnt} !== {1'b1, 4'd0, 2'd3} || r_lat != 2) begin
            errors++;
            $display("FAIL empty_entry0_written: hit=%0b idx=%0d cnt=%0d lat=%0d, expected 1/0/3 lat 2", r_hit, r_idx, r_cnt, r_lat);
        end
        checks++;
        do_word(32'h55667788);
        if ({r_hit, r_idx, r_cnt} !== {1'b0, 4'd0, 2'd0} || r_lat != 2) begin
            errors++;
            $display("FAIL empty_second_word: hit=%0b idx=%0d cnt=%0d lat=%0d, expected 0/0/0 lat 2", r_hit, r_idx, r_cnt, r_lat);
        end
        checks++;
        do_word(32'h55667788);
        if ({r_hit, r_idx, r_cnt} !== {1'b1, 4'd1, 2'd3} || r_lat != 3) begin
            errors++;
            $display("FAIL empty_wr_ptr1: hit=%0b idx=%0d cnt=%0d lat=%0d, expected 1/1/3 lat 3", r_hit, r_idx, r_cnt, r_lat);
        end
        checks++;
    endtask

    task automatic test_full_match();
        apply_reset();
        do_word(32'hAABBCCDD);
        do_word(32'h11223344);
        do_word(32'h11223344);
        if ({r_hit, r_idx, r_cnt} !== {1'b1, 4'd1, 2'd3} || r_lat != 3) begin
            errors++;
            $display("FAIL full_match_last: hit=%0b idx=%0d cnt=%0d lat=%0d, expected 1/1/3 lat 3", r_hit, r_idx, r_cnt, r_lat);
        end
        checks++;
        do_word(32'h99999999);
        if ({r_hit, r_idx, r_cnt} !== {1'b0, 4'd0, 2'd0} || r_lat != 3) begin
            errors++;
            $display("FAIL full_match_no_write_miss: hit=%0b idx=%0d cnt=%0d lat=%0d, expected 0/0/0 lat 3", r_hit, r_idx, r_cnt, r_lat);
        end
        checks++;
        do_word(32'h99999999);
        if ({r_hit, r_idx, r_cnt} !== {1'b1, 4'd2, 2'd3} || r_lat != 4) begin
            errors++;
            $display("FAIL full_match_wr_ptr_kept: hit=%0b idx=%0d cnt=%0d lat=%0d, expected 1/2/3 lat 4", r_hit, r_idx, r_cnt, r_lat);
        end
        checks++;
    endtask

    task automatic test_align();
        apply_reset();
        do_word(32'h00FF00FF);
        do_word(32'h1122AAAA);
        do_word(32'h1122BBBB);
        if ({r_hit, r_idx, r_cnt} !== {1'b1, 4'd1, 2'd1} || r_lat != 3) begin
            errors++;
            $display("FAIL align_two_bytes: hit=%0b idx=%0d cnt=%0d lat=%0d, expected 1/1/1 lat 3", r_hit, r_idx, r_cnt, r_lat);
        end
        checks++;
        do_word(32'h1122BBBB);
        if ({r_hit, r_idx, r_cnt} !== {1'b1, 4'd2, 2'd3} || r_lat != 4) begin
            errors++;
            $display("FAIL align_written_idx2: hit=%0b idx=%0d cnt=%0d lat=%0d, expected 1/2/3 lat 4", r_hit, r_idx, r_cnt, r_lat);
        end
        checks++;
        // Entry 0 matches three bytes but with a gap, so the aligned two-byte entry wins.
        apply_reset();
        do_word(32'h11AA3344);
        do_word(32'h1122CCDD);
        do_word(32'h11223344);
        if ({r_hit, r_idx, r_cnt} !== {1'b1, 4'd1, 2'd1}) begin
            errors++;
            $display("FAIL align_gap_rejected: hit=%0b idx=%0d cnt=%0d, expected 1/1/1", r_hit, r_idx, r_cnt);
        end
        checks++;
        apply_reset();
        do_word(32'h1122CCDD);
        do_word(32'h1122EEFF);
        if ({r_hit, r_idx, r_cnt} !== {1'b1, 4'd0, 2'd1}) begin
            errors++;
            $display("FAIL partial_hit: hit=%0b idx=%0d cnt=%0d, expected 1/0/1", r_hit, r_idx, r_cnt);
        end
        checks++;
        do_word(32'h11220000);
        if ({r_hit, r_idx, r_cnt} !== {1'b1, 4'd0, 2'd1}) begin
            errors++;
            $display("FAIL tie_lower_idx: hit=%0b idx=%0d cnt=%0d, expected 1/0/1", r_hit, r_idx, r_cnt);
        end
        checks++;
    endtask

    task automatic test_wrap();
        logic [7:0] b;
        int exp_lat;
        apply_reset();
        for (int k = 1; k <= 16; k++) begin
            b = 8'(k);
            do_word({b, b, b, b});
            if (r_hit !== 1'b0 || r_lat != k) begin
                errors++;
                $display("FAIL wrap_fill_%0d: hit=%0b lat=%0d, expected 0 lat %0d", k, r_hit, r_lat, k);
            end
            checks++;
        end
        b = 8'd17;
        do_word({b, b, b, b});
        if ({r_hit, r_idx, r_cnt} !== {1'b0, 4'd0, 2'd0} || r_lat != 17) begin
            errors++;
            $display("FAIL wrap_17th: hit=%0b idx=%0d cnt=%0d lat=%0d, expected 0/0/0 lat 17", r_hit, r_idx, r_cnt, r_lat);
        end
        checks++;
`ifdef DICT_EARLY_EXIT_EN
        exp_lat = 2;
`else
        exp_lat = 17;
`endif
        do_word({b, b, b, b});
        if ({r_hit, r_idx, r_cnt} !== {1'b1, 4'd0, 2'd3} || r_lat != exp_lat) begin
            errors++;
            $display("FAIL wrap_idx0: hit=%0b idx=%0d cnt=%0d lat=%0d, expected 1/0/3 lat %0d", r_hit, r_idx, r_cnt, r_lat, exp_lat);
        end
        checks++;
        b = 8'd1;
        do_word({b, b, b, b});
        if (r_hit !== 1'b0) begin
            errors++;
            $display("FAIL wrap_oldest_gone: hit=%0b, expected 0", r_hit);
        end
        checks++;
        do_word({b, b, b, b});
        if ({r_hit, r_idx, r_cnt} !== {1'b1, 4'd1, 2'd3}) begin
            errors++;
            $display("FAIL wrap_wr_ptr1: hit=%0b idx=%0d cnt=%0d, expected 1/1/3", r_hit, r_idx, r_cnt);
        end
        checks++;
    endtask

    task automatic test_hold_flush();
        int lat;
        apply_reset();
        do_word(32'hAABBCCDD);
        wait_ready();
        bus.i_word_valid = 1'b1;
        bus.i_word       = 32'hAABBCCDD;
        step();
        bus.i_word_valid = 1'b0;
        bus.i_word       = 32'h0;
        wait_res_valid(lat);
        for (int i = 0; i < 5; i++) begin
            if ({bus.o_res_valid, bus.o_res_hit, bus.o_res_idx, bus.o_res_count, bus.o_res_word, bus.o_word_ready}
                !== {1'b1, 1'b1, 4'd0, 2'd3, 32'hAABBCCDD, 1'b0}) begin
                errors++;
                $display("FAIL hold_stable_%0d: valid=%0b hit=%0b idx=%0d cnt=%0d word=%h ready=%0b, expected 1/1/0/3/aabbccdd/0",
                         i, bus.o_res_valid, bus.o_res_hit, bus.o_res_idx, bus.o_res_count, bus.o_res_word, bus.o_word_ready);
            end
            checks++;
            bus.i_flush = (i == 2);
            step();
            bus.i_flush = 1'b0;
        end
        bus.i_res_ready = 1'b1;
        step();
        bus.i_res_ready = 1'b0;
        if ({bus.o_res_valid, bus.o_word_ready} !== 2'b00) begin
            errors++;
            $display("FAIL hold_update_cycle: valid=%0b ready=%0b, expected 0/0", bus.o_res_valid, bus.o_word_ready);
        end
        checks++;
        step();
        if (bus.o_word_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_blocked: ready=%0b, expected 0", bus.o_word_ready);
        end
        checks++;
        step();
        if (bus.o_word_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_ready_return: ready=%0b, expected 1", bus.o_word_ready);
        end
        checks++;
        do_word(32'hAABBCCDD);
        if ({r_hit, r_idx, r_cnt} !== {1'b0, 4'd0, 2'd0} || r_lat != 1) begin
            errors++;
            $display("FAIL flush_cleared: hit=%0b idx=%0d cnt=%0d lat=%0d, expected 0/0/0 lat 1", r_hit, r_idx, r_cnt, r_lat);
        end
        checks++;
    endtask

    task automatic test_reset_mid_scan();
        apply_reset();
        do_word(32'hAABBCCDD);
        do_word(32'h11223344);
        wait_ready();
        bus.i_word_valid = 1'b1;
        bus.i_word       = 32'h11223344;
        step();
        bus.i_word_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        if ({bus.o_word_ready, bus.o_res_valid, bus.o_res_hit, bus.o_res_idx, bus.o_res_count, bus.o_res_word} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: ready=%0b valid=%0b hit=%0b idx=%0d cnt=%0d word=%h, expected all 0",
                     bus.o_word_ready, bus.o_res_valid, bus.o_res_hit, bus.o_res_idx, bus.o_res_count, bus.o_res_word);
        end
        checks++;
        rst = 1'b0;
        step();
        do_word(32'h11223344);
        if ({r_hit, r_idx, r_cnt} !== {1'b0, 4'd0, 2'd0} || r_lat != 1) begin
            errors++;
            $display("FAIL reset_mid_empty: hit=%0b idx=%0d cnt=%0d lat=%0d, expected 0/0/0 lat 1", r_hit, r_idx, r_cnt, r_lat);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        int acc[$];
        apply_reset();
        bus.i_word       = 32'h5A5A5A5A;
        bus.i_word_valid = 1'b1;
        bus.i_res_ready  = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (bus.o_word_ready && bus.i_word_valid) acc.push_back(cyc);
            step();
        end
        bus.i_word_valid = 1'b0;
        bus.i_res_ready  = 1'b0;
        if (acc.size() != 4) begin
            errors++;
            $display("FAIL b2b_accept_count: got %0d accepts, expected 4", acc.size());
        end else if (acc[1] - acc[0] != 3 || acc[2] - acc[1] != 4 || acc[3] - acc[2] != 4) begin
            errors++;
            $display("FAIL b2b_spacing: intervals %0d %0d %0d, expected 3 4 4", acc[1] - acc[0], acc[2] - acc[1], acc[3] - acc[2]);
        end
        checks++;
    endtask

    initial begin
        bus.i_word_valid = 1'b0;
        bus.i_word       = 32'h0;
        bus.i_flush      = 1'b0;
        bus.i_res_ready  = 1'b0;
        test_reset();
        test_empty_dict();
        test_full_match();
        test_align();
        test_wrap();
        test_hold_flush();
        test_reset_mid_scan();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
